// File: rtl/enclave_cmd_scheduler_pkg.sv
// enclave_cmd_scheduler_pkg: opcode encodings and scheduler state codes
package enclave_cmd_scheduler_pkg;
  typedef enum logic [1:0] {
    OPCODE_ENCRYPT = 2'd0,
    OPCODE_DECRYPT = 2'd1,
    OPCODE_ADD     = 2'd2,
    OPCODE_MULT    = 2'd3
  } opcode_e;
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_CONFIG = 3'd1;
  localparam logic [2:0] ST_GUARD  = 3'd2;
  localparam logic [2:0] ST_RUN    = 3'd3;
  localparam logic [2:0] ST_CPL    = 3'd4;
  function automatic int entry_width(input int aw, input int bn, input int tw);
    return 2 + 3 * aw + bn + tw;
  endfunction
endpackage

// File: rtl/enclave_cmd_scheduler_if.sv
// enclave_cmd_scheduler_if: host command, controller and completion signals of the scheduler
interface enclave_cmd_scheduler_if #(
  parameter int ADDR_WIDTH = 10,
  parameter int BIG_N      = 30,
  parameter int TAG_WIDTH  = 4,
  parameter int PTR_WIDTH  = 2
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [1:0]            cmd_opcode;
  logic [ADDR_WIDTH-1:0] cmd_op1_addr;
  logic [ADDR_WIDTH-1:0] cmd_op2_addr;
  logic [ADDR_WIDTH-1:0] cmd_out_addr;
  logic [BIG_N-1:0]      cmd_noise;
  logic [TAG_WIDTH-1:0]  cmd_tag;
  logic [1:0]            ctl_opcode;
  logic                  ctl_config_en;
  logic [ADDR_WIDTH-1:0] ctl_op1_addr;
  logic [ADDR_WIDTH-1:0] ctl_op2_addr;
  logic [ADDR_WIDTH-1:0] ctl_out_addr;
  logic [BIG_N-1:0]      ctl_noise;
  logic                  ctl_done;
  logic                  cpl_valid;
  logic                  cpl_ready;
  logic [TAG_WIDTH-1:0]  cpl_tag;
  logic                  cpl_timeout;
  logic                  busy;
  logic [PTR_WIDTH:0]    fifo_count;
  modport slave (
    input  cmd_valid, cmd_opcode, cmd_op1_addr, cmd_op2_addr, cmd_out_addr, cmd_noise, cmd_tag,
    input  ctl_done, cpl_ready,
    output cmd_ready, ctl_opcode, ctl_config_en, ctl_op1_addr, ctl_op2_addr, ctl_out_addr, ctl_noise,
    output cpl_valid, cpl_tag, cpl_timeout, busy, fifo_count
  );
  modport master (
    output cmd_valid, cmd_opcode, cmd_op1_addr, cmd_op2_addr, cmd_out_addr, cmd_noise, cmd_tag,
    output ctl_done, cpl_ready,
    input  cmd_ready, ctl_opcode, ctl_config_en, ctl_op1_addr, ctl_op2_addr, ctl_out_addr, ctl_noise,
    input  cpl_valid, cpl_tag, cpl_timeout, busy, fifo_count
  );
endinterface

// File: rtl/enclave_cmd_fifo.sv
// enclave_cmd_fifo: synchronous command FIFO with registered occupancy count
module enclave_cmd_fifo #(
  parameter int WIDTH     = 76,
  parameter int DEPTH     = 4,
  parameter int PTR_WIDTH = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               push,
  input  logic               pop,
  input  logic [WIDTH-1:0]   din,
  output logic [WIDTH-1:0]   dout,
  output logic               full,
  output logic               empty,
  output logic [PTR_WIDTH:0] count
);
  logic [WIDTH-1:0]     mem_q [DEPTH];
  logic [PTR_WIDTH-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [PTR_WIDTH:0]   cnt_q, cnt_d;
  // pointers wrap naturally because DEPTH is a power of two
  always_comb begin
    wr_d  = push ? wr_q + PTR_WIDTH'(1) : wr_q;
    rd_d  = pop ? rd_q + PTR_WIDTH'(1) : rd_q;
    cnt_d = cnt_q + (PTR_WIDTH+1)'(push) - (PTR_WIDTH+1)'(pop);
  end
  // pointer and count state
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end
  // storage needs no reset; only entries below the count are ever read
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= din;
  end
  assign dout  = mem_q[rd_q];
  assign full  = cnt_q == (PTR_WIDTH+1)'(DEPTH);
  assign empty = cnt_q == '0;
  assign count = cnt_q;
endmodule

// File: rtl/enclave_cmd_scheduler.sv
// enclave_cmd_scheduler: queues host op commands and issues them one at a time to the op controller
module enclave_cmd_scheduler
  import enclave_cmd_scheduler_pkg::*;
#(
  parameter int ADDR_WIDTH     = 10,
  parameter int BIG_N          = 30,
  parameter int TAG_WIDTH      = 4,
  parameter int DEPTH          = 4,
  parameter int PTR_WIDTH      = 2,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int TMO_WIDTH      = 11
) (
  input logic                   clk,
  input logic                   rst_n,
  enclave_cmd_scheduler_if.slave bus
);
  localparam int W = entry_width(ADDR_WIDTH, BIG_N, TAG_WIDTH);
  logic                  push, pop, full, empty;
  logic [W-1:0]          din, dout;
  logic [PTR_WIDTH:0]    count;
  logic [2:0]            state_q, state_d;
  logic [1:0]            opcode_q, opcode_d;
  logic [ADDR_WIDTH-1:0] op1_q, op1_d, op2_q, op2_d, out_q, out_d;
  logic [BIG_N-1:0]      noise_q, noise_d;
  logic [TAG_WIDTH-1:0]  tag_q, tag_d;
  logic                  cfg_q, cfg_d, cpl_valid_q, cpl_valid_d, timeout_q, timeout_d;
  logic [TMO_WIDTH-1:0]  wd_q, wd_d;
  assign push = bus.cmd_valid && !full;
  assign din  = {bus.cmd_opcode, bus.cmd_op1_addr, bus.cmd_op2_addr, bus.cmd_out_addr, bus.cmd_noise, bus.cmd_tag};
  enclave_cmd_fifo #(.WIDTH(W), .DEPTH(DEPTH), .PTR_WIDTH(PTR_WIDTH)) u_fifo (
    .clk(clk), .rst_n(rst_n), .push(push), .pop(pop), .din(din), .dout(dout),
    .full(full), .empty(empty), .count(count)
  );
  // issue sequence: load head, pulse config, skip the stale done, run under watchdog, hold completion
  always_comb begin
    state_d     = state_q;
    {opcode_d, op1_d, op2_d, out_d, noise_d, tag_d} = {opcode_q, op1_q, op2_q, out_q, noise_q, tag_q};
    cfg_d       = 1'b0;
    cpl_valid_d = cpl_valid_q;
    timeout_d   = timeout_q;
    wd_d        = wd_q;
    pop         = 1'b0;
    case (state_q)
      ST_IDLE: if (!empty) begin
        pop     = 1'b1;
        {opcode_d, op1_d, op2_d, out_d, noise_d, tag_d} = dout;
        cfg_d   = 1'b1;
        state_d = ST_CONFIG;
      end
      ST_CONFIG: state_d = ST_GUARD;
      ST_GUARD: begin
        wd_d    = '0;
        state_d = ST_RUN;
      end
      ST_RUN: if (bus.ctl_done || wd_q == TMO_WIDTH'(TIMEOUT_CYCLES - 1)) begin
        state_d     = ST_CPL;
        cpl_valid_d = 1'b1;
        timeout_d   = !bus.ctl_done;
      end else begin
        wd_d = wd_q + TMO_WIDTH'(1);
      end
      ST_CPL: if (bus.cpl_ready) begin
        cpl_valid_d = 1'b0;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end
  // scheduler state and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      opcode_q    <= '0;
      op1_q       <= '0;
      op2_q       <= '0;
      out_q       <= '0;
      noise_q     <= '0;
      tag_q       <= '0;
      cfg_q       <= 1'b0;
      cpl_valid_q <= 1'b0;
      timeout_q   <= 1'b0;
      wd_q        <= '0;
    end else begin
      state_q     <= state_d;
      opcode_q    <= opcode_d;
      op1_q       <= op1_d;
      op2_q       <= op2_d;
      out_q       <= out_d;
      noise_q     <= noise_d;
      tag_q       <= tag_d;
      cfg_q       <= cfg_d;
      cpl_valid_q <= cpl_valid_d;
      timeout_q   <= timeout_d;
      wd_q        <= wd_d;
    end
  end
  assign bus.cmd_ready     = !full;
  assign bus.ctl_opcode    = opcode_q;
  assign bus.ctl_config_en = cfg_q;
  assign bus.ctl_op1_addr  = op1_q;
  assign bus.ctl_op2_addr  = op2_q;
  assign bus.ctl_out_addr  = out_q;
  assign bus.ctl_noise     = noise_q;
  assign bus.cpl_valid     = cpl_valid_q;
  assign bus.cpl_tag       = tag_q;
  assign bus.cpl_timeout   = timeout_q;
  assign bus.busy          = (state_q != ST_IDLE) || !empty;
  assign bus.fifo_count    = count;
endmodule

// File: tb/tb_enclave_cmd_scheduler.sv
// tb_enclave_cmd_scheduler: randomized host/controller stimulus checked against a cycle-timed transaction model
module tb_enclave_cmd_scheduler;
  import enclave_cmd_scheduler_pkg::*;
  localparam int AW = 10, BN = 30, TW = 4, DEPTH = 4, PW = 2, TMO = 1024;
  typedef struct packed {
    logic [1:0]    op;
    logic [AW-1:0] a1;
    logic [AW-1:0] a2;
    logic [AW-1:0] ao;
    logic [BN-1:0] n;
    logic [TW-1:0] tag;
  } cmd_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  enclave_cmd_scheduler_if #(.ADDR_WIDTH(AW), .BIG_N(BN), .TAG_WIDTH(TW), .PTR_WIDTH(PW)) bus ();
  enclave_cmd_scheduler #(
    .ADDR_WIDTH(AW), .BIG_N(BN), .TAG_WIDTH(TW), .DEPTH(DEPTH), .PTR_WIDTH(PW),
    .TIMEOUT_CYCLES(TMO), .TMO_WIDTH(11)
  ) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  cmd_t host[$];
  cmd_t q[$];
  cmd_t cur = '0;
  int   force_q[$];
  int   cyc = 0, cfg_at = -100, done_at = -1;
  bit   in_op = 0, cpl_on = 0, exp_to = 0, done_lvl = 0;
  int   gen_pct = 0, rdy_pct = 100, never_pct = 0, dmax = 8;
  int   n_chk = 0, n_pass = 0;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
  endtask
  function automatic cmd_t rand_cmd();
    cmd_t c;
    c.op  = 2'($urandom);
    c.a1  = AW'($urandom);
    c.a2  = AW'($urandom);
    c.ao  = AW'($urandom);
    c.n   = BN'($urandom);
    c.tag = TW'($urandom);
    return c;
  endfunction
  function automatic cmd_t mk(input logic [1:0] op, input logic [AW-1:0] a1, input logic [AW-1:0] a2,
                              input logic [AW-1:0] ao, input logic [TW-1:0] tag);
    cmd_t c;
    c = rand_cmd();
    c.op = op; c.a1 = a1; c.a2 = a2; c.ao = ao; c.tag = tag;
    return c;
  endfunction
  task automatic step(input bit rst = 1'b0);
    cmd_t h;
    bit do_push, do_pop;
    int r;
    @(negedge clk);
    chk("config_en", bus.ctl_config_en, cyc == cfg_at);
    chk("cmd_ready", bus.cmd_ready, q.size() < DEPTH);
    chk("fifo_count", bus.fifo_count, q.size());
    chk("busy", bus.busy, in_op || q.size() != 0);
    chk("cpl_valid", bus.cpl_valid, cpl_on);
    chk("ctl_fields", {bus.ctl_opcode, bus.ctl_op1_addr, bus.ctl_op2_addr, bus.ctl_out_addr, bus.ctl_noise},
        {cur.op, cur.a1, cur.a2, cur.ao, cur.n});
    if (cpl_on) begin
      chk("cpl_tag", bus.cpl_tag, cur.tag);
      chk("cpl_timeout", bus.cpl_timeout, exp_to);
    end
    if (host.size() == 0 && $urandom_range(99) < gen_pct) host.push_back(rand_cmd());
    h = host.size() != 0 ? host[0] : rand_cmd();
    bus.cmd_valid    = host.size() != 0;
    bus.cmd_opcode   = h.op;
    bus.cmd_op1_addr = h.a1;
    bus.cmd_op2_addr = h.a2;
    bus.cmd_out_addr = h.ao;
    bus.cmd_noise    = h.n;
    bus.cmd_tag      = h.tag;
    if (in_op && cyc >= cfg_at + 2) done_lvl = done_at >= 0 && cyc >= done_at;
    bus.ctl_done  = done_lvl;
    bus.cpl_ready = $urandom_range(99) < rdy_pct;
    rst_n = !rst;
    if (rst) begin
      q.delete();
      in_op = 0; cpl_on = 0; done_lvl = 0; cfg_at = -100; cur = '0;
    end else begin
      do_pop  = !in_op && q.size() != 0;
      do_push = bus.cmd_valid && q.size() < DEPTH;
      if (cpl_on && bus.cpl_ready) begin
        cpl_on = 0; in_op = 0;
      end else if (in_op && !cpl_on && cyc >= cfg_at + 2) begin
        if (done_lvl) begin cpl_on = 1; exp_to = 0; end
        else if (cyc - cfg_at - 2 == TMO - 1) begin cpl_on = 1; exp_to = 1; end
      end
      if (do_pop) begin
        cur = q.pop_front();
        in_op = 1;
        cfg_at = cyc + 1;
        if (force_q.size() != 0) r = force_q.pop_front();
        else r = ($urandom_range(99) < never_pct) ? -1 : int'($urandom_range(dmax));
        done_at = r < 0 ? -1 : cfg_at + 2 + r;
      end
      if (do_push) q.push_back(host.pop_front());
    end
    @(posedge clk);
    cyc++;
  endtask
  task automatic drain();
    int n = 0;
    while ((in_op || q.size() != 0 || host.size() != 0) && n < 5000) begin step(); n++; end
    chk("drain_bound", n < 5000, 1);
  endtask
  initial begin
    int n;
    bus.cmd_valid = 0; bus.cmd_opcode = 0; bus.cmd_op1_addr = 0; bus.cmd_op2_addr = 0;
    bus.cmd_out_addr = 0; bus.cmd_noise = 0; bus.cmd_tag = 0; bus.ctl_done = 0; bus.cpl_ready = 0;
    repeat (2) @(posedge clk);
    step(); step();
    force_q.push_back(10);
    host.push_back(mk(OPCODE_ADD, 10'h010, 10'h020, 10'h030, 4'd5));
    drain(); repeat (3) step();
    force_q.push_back(30);
    host.push_back(mk(OPCODE_MULT, 10'h3ff, 10'h155, 10'h2aa, 4'd15));
    for (int t = 0; t < 5; t++) begin
      force_q.push_back(3 + t);
      host.push_back(mk(2'(t), AW'(t * 17), AW'(t * 33), AW'(t * 65), TW'(t)));
    end
    drain();
    force_q.push_back(-1); force_q.push_back(2);
    host.push_back(mk(OPCODE_ENCRYPT, 10'h100, 10'h101, 10'h102, 4'd7));
    host.push_back(mk(OPCODE_DECRYPT, 10'h200, 10'h201, 10'h202, 4'd8));
    drain();
    force_q.push_back(TMO - 1);
    host.push_back(mk(OPCODE_ADD, 10'h011, 10'h022, 10'h033, 4'd9));
    drain();
    force_q.push_back(5); force_q.push_back(0);
    host.push_back(mk(OPCODE_MULT, 10'h044, 10'h055, 10'h066, 4'd10));
    host.push_back(mk(OPCODE_ADD, 10'h077, 10'h088, 10'h099, 4'd11));
    rdy_pct = 0;
    n = 0;
    while (!cpl_on && n < 200) begin step(); n++; end
    chk("reach_cpl", n < 200, 1);
    repeat (7) step();
    rdy_pct = 100;
    drain();
    gen_pct = 35; rdy_pct = 70; dmax = 20;
    repeat (1500) step();
    gen_pct = 0;
    drain();
    force_q.push_back(-1);
    for (int t = 0; t < 3; t++) host.push_back(mk(2'(t), AW'(t + 1), AW'(t + 2), AW'(t + 3), TW'(t + 12)));
    n = 0;
    while (!(in_op && cyc >= cfg_at + 2 && q.size() >= 2) && n < 200) begin step(); n++; end
    chk("reach_run", n < 200, 1);
    host.delete(); force_q.delete();
    step(1'b1);
    repeat (20) step();
    host.push_back(mk(OPCODE_DECRYPT, 10'h321, 10'h123, 10'h231, 4'd3));
    drain(); repeat (3) step();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
